// File: rtl/phit_pkg.sv
// Shared defaults and types for the phit receive path.
// Index widths are derived with idx_width() so a single VC or a one-phit flit still gets a 1-bit index.
package phit_pkg;

  localparam int FLIT_SIZE_DEF = 4;
  localparam int PHIT_SIZE_DEF = 16;
  localparam int NUM_VC_DEF    = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int VC_W_DEF  = idx_width(NUM_VC_DEF);
  localparam int PTR_W_DEF = idx_width(FLIT_SIZE_DEF);

  typedef logic [PHIT_SIZE_DEF-1:0]               phit_t;
  typedef logic [FLIT_SIZE_DEF*PHIT_SIZE_DEF-1:0] flit_t;

endpackage

// File: rtl/phit_rec_vc_rr_arb.sv
// Combinational round-robin picker: the first set bit of req, searching upward from base and wrapping.
// base must be a valid index (< N).
module rr_arb #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] base,
  output logic [W-1:0] grant,
  output logic         any
);

  always_comb begin
    grant = '0;
    any   = 1'b0;
    // Outer loop walks the search distance from base; inner loop finds the matching slot.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!any && req[j] && (((int'(base) + i) % N) == j)) begin
          grant = W'(j);
          any   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/phit_rec_vc.sv
// Multi-VC phit-to-flit reassembler with one-entry flit buffers per VC and a round-robin output port.
// Optional macro PHIT_REC_ERR_EN adds sticky err / err_vc reporting of dropped phits.
module phit_rec_vc
  import phit_pkg::*;
#(
  parameter int FLIT_SIZE = FLIT_SIZE_DEF,
  parameter int PHIT_SIZE = PHIT_SIZE_DEF,
  parameter int NUM_VC    = NUM_VC_DEF,
  parameter int VC_W      = VC_W_DEF,
  parameter int PTR_W     = PTR_W_DEF
) (
  input  logic                           clk,
  input  logic                           rs,
  input  logic [PHIT_SIZE-1:0]           indata,
  input  logic                           new_phit,
  input  logic                           en,
  input  logic [VC_W-1:0]                in_vc,
  output logic [NUM_VC-1:0]              phit_rdy,
  output logic [FLIT_SIZE*PHIT_SIZE-1:0] outdata,
  output logic [VC_W-1:0]                out_vc,
  output logic                           valid,
  input  logic                           out_ready
`ifdef PHIT_REC_ERR_EN
  ,
  output logic                           err,
  output logic [VC_W-1:0]                err_vc
`endif
);

  localparam int FW = FLIT_SIZE * PHIT_SIZE;

  logic [NUM_VC-1:0] acc_vc;
  logic [NUM_VC-1:0] full;
  logic [NUM_VC-1:0] cur_oh;
  logic [NUM_VC-1:0] req;
  logic [FW-1:0]     flit_buf [NUM_VC];

  logic              valid_reg, valid_next;
  logic [VC_W-1:0]   cur_vc_reg, cur_vc_next;
  logic [VC_W-1:0]   arb_base, grant;
  logic              any, pop;

  assign pop = valid_reg & out_ready;

  generate
    for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
      logic          full_reg;
      logic [FW-1:0] flit_buf_reg;

      // An in_vc beyond NUM_VC matches no lane, so it is never accepted.
      assign acc_vc[gi]   = en & new_phit & phit_rdy[gi] & (in_vc == VC_W'(gi));
      assign cur_oh[gi]   = (cur_vc_reg == VC_W'(gi));
      assign full[gi]     = full_reg;
      assign flit_buf[gi] = flit_buf_reg;

      if (FLIT_SIZE == 1) begin : g_direct
        assign phit_rdy[gi] = ~full_reg;

        // Acceptance needs ~full, so it never coincides with a pop of this VC.
        always_ff @(posedge clk or negedge rs) begin
          if (!rs) begin
            full_reg     <= 1'b0;
            flit_buf_reg <= '0;
          end else if (acc_vc[gi]) begin
            flit_buf_reg <= indata;
            full_reg     <= 1'b1;
          end else if (pop && cur_oh[gi]) begin
            full_reg <= 1'b0;
          end
        end
      end else begin : g_staged
        localparam logic [PTR_W-1:0] LAST = PTR_W'(FLIT_SIZE - 1);

        logic [PTR_W-1:0]                   ptr_reg;
        logic [(FLIT_SIZE-1)*PHIT_SIZE-1:0] stage_flat;

        // Only the final phit is blocked: earlier phits can stage while the buffer drains.
        assign phit_rdy[gi] = ~((ptr_reg == LAST) & full_reg);

        for (genvar gp = 0; gp < FLIT_SIZE - 1; gp++) begin : g_slot
          logic [PHIT_SIZE-1:0] slot_reg;
          assign stage_flat[gp*PHIT_SIZE +: PHIT_SIZE] = slot_reg;

          always_ff @(posedge clk or negedge rs) begin
            if (!rs) begin
              slot_reg <= '0;
            end else if (acc_vc[gi] && (ptr_reg == PTR_W'(gp))) begin
              slot_reg <= indata;
            end
          end
        end

        always_ff @(posedge clk or negedge rs) begin
          if (!rs) begin
            ptr_reg      <= '0;
            full_reg     <= 1'b0;
            flit_buf_reg <= '0;
          end else if (acc_vc[gi] && (ptr_reg == LAST)) begin
            flit_buf_reg <= {indata, stage_flat};
            full_reg     <= 1'b1;
            ptr_reg      <= '0;
          end else begin
            if (acc_vc[gi]) ptr_reg <= ptr_reg + PTR_W'(1);
            if (pop && cur_oh[gi]) full_reg <= 1'b0;
          end
        end
      end
    end
  endgenerate

  // The VC being popped is masked so it cannot be re-granted on the same edge.
  assign req      = full & ~(pop ? cur_oh : '0);
  assign arb_base = (cur_vc_reg == VC_W'(NUM_VC - 1)) ? '0 : cur_vc_reg + VC_W'(1);

  rr_arb #(
    .N (NUM_VC),
    .W (VC_W)
  ) u_arb (
    .req   (req),
    .base  (arb_base),
    .grant (grant),
    .any   (any)
  );

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      valid_reg  <= 1'b0;
      cur_vc_reg <= '0;
    end else begin
      valid_reg  <= valid_next;
      cur_vc_reg <= cur_vc_next;
    end
  end

  always_comb begin
    valid_next  = valid_reg;
    cur_vc_next = cur_vc_reg;
    if (!valid_reg || pop) begin
      valid_next = any;
      if (any) cur_vc_next = grant;
    end
  end

  always_comb begin
    valid   = valid_reg;
    out_vc  = cur_vc_reg;
    outdata = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (cur_oh[i]) outdata = flit_buf[i];
    end
  end

`ifdef PHIT_REC_ERR_EN
  logic            drop;
  logic            err_reg;
  logic [VC_W-1:0] err_vc_reg;

  assign drop = en & new_phit & ~(|acc_vc);

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      err_reg    <= 1'b0;
      err_vc_reg <= '0;
    end else if (drop && !err_reg) begin
      err_reg    <= 1'b1;
      err_vc_reg <= in_vc;
    end
  end

  assign err    = err_reg;
  assign err_vc = err_vc_reg;
`endif

endmodule

// File: doc/phit_rec_vc.md
# phit_rec_vc

Multi-virtual-channel phit-to-flit reassembler for the link receive path. It collects FLIT_SIZE phits per virtual channel (VC) into a flit and parks each completed flit in a one-entry per-VC buffer. It then presents flits to the router input stage through a round-robin-arbitrated valid/ready port. Upstream link logic receives per-VC phit back-pressure.

## Interface
- FLIT_SIZE, 4: phits per flit (≥1)
- PHIT_SIZE, 16: bits per phit
- NUM_VC, 2: virtual channels (≥1)
- VC_W, 1: width of VC index, ≥ max(1, ceil(log2 NUM_VC))
- PTR_W, 2: phit pointer width, ≥ max(1, ceil(log2 FLIT_SIZE))
- clk  in  1  clock, rising edge
- rs  in  1  reset, asynchronous, active-low
- indata  in  PHIT_SIZE  incoming phit
- new  in  1  indata carries a phit this cycle
- en  in  1  receiver enable; phits ignored when low
- in_vc  in  VC_W  VC of incoming phit
- phit_rdy  out  NUM_VC  VC v can accept a phit this cycle
- outdata  out  FLIT_SIZE*PHIT_SIZE  flit; phit 0 (first received) in LSBs, last phit in MSBs
- out_vc  out  VC_W  VC of presented flit
- valid  out  1  flit presented
- out_ready  in  1  downstream accepts flit

## Operation
- Phit accept: acc = en & new & phit_rdy[in_vc] & (in_vc < NUM_VC).
- phit_rdy[v] = ~(ptr[v]==FLIT_SIZE-1 & full[v]). It depends on registered state only, never on out_ready.
- On acc with ptr<FLIT_SIZE-1: stage[in_vc][ptr] <= indata; ptr++.
- On acc with ptr==FLIT_SIZE-1: buf[in_vc] <= {indata, stage[in_vc][FLIT_SIZE-2:0]}; full[in_vc] <= 1; ptr <= 0.
- FLIT_SIZE==1: there is no staging, and every accepted phit completes a flit.
- Phits on different VCs may interleave freely. Each VC's pointer is independent.
- Output state: registers valid and cur_vc. outdata = buf[cur_vc]; out_vc = cur_vc.
- pop = valid & out_ready. On pop: full[cur_vc] <= 0.
- Load rule: when ~valid | pop, search req = full & ~(pop ? onehot(cur_vc) : 0) round-robin from cur_vc+1.
  - If a request is found: valid <= 1 and cur_vc <= winner.
  - Otherwise: valid <= 0.
- While valid & ~out_ready, valid, out_vc and outdata hold stable. A newly full VC never preempts.
- Same-edge completion and pop on the same VC cannot occur, because phit_rdy blocks it.
- Completion on VC a and pop of VC b in the same cycle are both honoured.
- Dropped phits: phits with ~phit_rdy[in_vc] or in_vc ≥ NUM_VC are discarded and leave no state change (see Configuration).

## Timing
- Reset values: ptr=0, full=0, stage=0, buf=0, valid=0, cur_vc=0. Outputs: outdata=0, out_vc=0, valid=0, phit_rdy=all 1s.
- Latency: last phit accepted at edge k → full at k → valid high after edge k+1 (if the output is idle).
- Per-VC sustained rate: one flit per max(FLIT_SIZE, 3) cycles with out_ready tied high. With FLIT_SIZE=1 the one-entry buffer blocks for 2 cycles; this is accepted.
- Round-robin fairness: with all VCs full and out_ready=1, grants rotate v, v+1, … with one flit per cycle.
- Reset mid-operation: partial flits and held flits are discarded immediately (asynchronous). The first edge after rs deasserts is a normal cycle.

## Configuration
- PHIT_REC_ERR_EN defined:
  - Adds output port err (1 bit).
  - err is sticky and set on any dropped phit. It clears only on reset.
  - Adds output err_vc (VC_W), which captures in_vc of the first drop.
- Undefined: drops are silent, and neither port exists.

## Structure
- Shared package phit_pkg: FLIT_SIZE/PHIT_SIZE/NUM_VC defaults, phit_t and flit_t typedefs, and the clog2-based VC_W/PTR_W helper constants.
- One sub-module, rr_arb: a NUM_VC-wide round-robin picker (req, base index → grant index, any). It is combinational and reusable in the router.

## Test plan
- Single VC, FLIT_SIZE=4, phits 0x1111,0x2222,0x3333,0x4444 on consecutive cycles, out_ready=1 → valid for 1 cycle, 2 cycles after the last phit, with outdata=0x4444_3333_2222_1111 and out_vc=0.
- NUM_VC=2 with interleaved phits A0,B0,A1,B1,A2,B2,A3,B3 → flit A (out_vc=0) presented, then flit B (out_vc=1) the next cycle, each correctly ordered.
- out_ready=0 with both VCs full → valid and outdata stay stable, and phit_rdy drops to 0 for both VCs once their next flits reach the last phit. Raising out_ready pops VC0 then VC1.
- A phit sent to a blocked VC, or to in_vc=3 with NUM_VC=2 → phit dropped and no state change. With PHIT_REC_ERR_EN: err=1 and err_vc=the first offending VC.
- rs asserted after 2 of 4 phits on VC0 → immediately valid=0 and phit_rdy=all 1s. A new 4-phit sequence after release yields exactly those 4 phits.
- FLIT_SIZE=1, NUM_VC=1, continuous new=1 → accepted phits appear on outdata in order, and no phit is accepted while phit_rdy=0.
